// File: rtl/counter_pkg.sv
// Shared CPU constants used by the address counter and its neighbours.
package counter_pkg;

    localparam int unsigned CPU_DATA_WIDTH = 8;

endpackage : counter_pkg

// File: rtl/counter.sv
// Loadable up/down address counter with a tri-state data-bus port and a one-cycle wrap flag.
// addrOut is always driven; dataBus carries the count only while oe is high.
module counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = CPU_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             oe,
    input  logic             wr,
    input  logic             dir,
    input  logic             en,
    inout  wire  [WIDTH-1:0] dataBus,
    output logic [WIDTH-1:0] addrOut,
    output logic             ov
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ov_q, ov_d;

    // Load beats count; ov defaults low so it can only ever be a single-edge pulse.
    always_comb begin
        count_d = count_q;
        ov_d    = 1'b0;
        if (wr) begin
            count_d = dataBus;
        end else if (en) begin
            if (!dir) begin
                count_d = count_q + 1'b1;
                ov_d    = &count_q;
            end else begin
                count_d = count_q - 1'b1;
                ov_d    = ~|count_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            ov_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            ov_q    <= ov_d;
        end
    end

    assign addrOut = count_q;
    assign ov      = ov_q;
    assign dataBus = oe ? count_q : {WIDTH{1'bz}};

endmodule : counter

// File: tb/tb_counter.sv
// Self-checking bench for the address counter: directed scenarios plus a randomized run
// against a small reference model, with expected {ov, count} pairs queued per edge.
module tb_counter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         oe;
  logic         wr;
  logic         dir;
  logic         en;
  logic [W-1:0] tb_data;
  logic         tb_drive;
  wire  [W-1:0] dataBus;
  logic [W-1:0] addrOut;
  logic         ov;

  int checks = 0;
  int errors = 0;

  logic [W:0]   exp_q[$];
  logic [W-1:0] m_count;
  logic         m_ov;

  assign dataBus = tb_drive ? tb_data : {W{1'bz}};

  counter #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .oe      (oe),
    .wr      (wr),
    .dir     (dir),
    .en      (en),
    .dataBus (dataBus),
    .addrOut (addrOut),
    .ov      (ov)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_out(input string tag);
    logic [W:0] exp;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      check_eq(tag, {23'd0, ov, addrOut}, {23'd0, exp});
    end
  endtask

  // driver: apply one edge of stimulus, queue its expected result, check after the edge
  task automatic drive(input string tag, input logic w, input logic e, input logic d,
                       input logic [W-1:0] data, input logic [W:0] exp);
    @(negedge clk);
    wr       = w;
    en       = e;
    dir      = d;
    tb_data  = data;
    tb_drive = w;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  // reference model for the random phase
  function automatic logic [W:0] predict(input logic w, input logic e, input logic d,
                                         input logic [W-1:0] data);
    int nxt;
    if (w) begin
      m_count = data;
      m_ov    = 1'b0;
    end else if (e && !d) begin
      nxt     = (int'(m_count) + 1) % (1 << W);
      m_ov    = (nxt == 0);
      m_count = W'(nxt);
    end else if (e && d) begin
      m_ov    = (m_count == '0);
      nxt     = (int'(m_count) + (1 << W) - 1) % (1 << W);
      m_count = W'(nxt);
    end else begin
      m_ov    = 1'b0;
    end
    return {m_ov, m_count};
  endfunction

  initial begin
    logic [W-1:0] v;
    logic         rw, re, rd;
    logic [W-1:0] rdata;

    rst = 1'b1; oe = 1'b1; wr = 1'b0; dir = 1'b0; en = 1'b0;
    tb_data = '0; tb_drive = 1'b0;
    #1;
    check_eq("reset_count", {24'd0, addrOut}, 32'h00);
    check_eq("reset_ov", {31'd0, ov}, 32'd0);
    check_eq("reset_bus_oe", {24'd0, dataBus}, 32'h00);
    @(negedge clk);
    oe  = 1'b0;
    rst = 1'b0;

    // load then up-count
    drive("load_10", 1'b1, 1'b0, 1'b0, 8'h10, {1'b0, 8'h10});
    for (int i = 1; i <= 5; i++) begin
      v = 8'h10 + W'(i);
      drive("up_step", 1'b0, 1'b1, 1'b0, 8'h00, {1'b0, v});
    end

    // up-wrap
    drive("load_fe", 1'b1, 1'b0, 1'b0, 8'hFE, {1'b0, 8'hFE});
    drive("upwrap_ff", 1'b0, 1'b1, 1'b0, 8'h00, {1'b0, 8'hFF});
    drive("upwrap_00", 1'b0, 1'b1, 1'b0, 8'h00, {1'b1, 8'h00});
    drive("upwrap_01", 1'b0, 1'b1, 1'b0, 8'h00, {1'b0, 8'h01});

    // down-count and down-wrap
    drive("load_05", 1'b1, 1'b0, 1'b0, 8'h05, {1'b0, 8'h05});
    for (int i = 1; i <= 8; i++) begin
      v = 8'h05 - W'(i);
      drive("down_step", 1'b0, 1'b1, 1'b1, 8'h00, {(v == 8'hFF), v});
    end

    // bus enable and high-impedance
    @(negedge clk);
    tb_drive = 1'b0; wr = 1'b0; en = 1'b0;
    oe = 1'b1;
    #1;
    check_eq("bus_oe_on", {24'd0, dataBus}, 32'hFD);
    oe = 1'b0;
    tb_data = 8'h5A; tb_drive = 1'b1;
    #1;
    check_eq("bus_oe_off", {24'd0, dataBus}, 32'h5A);
    tb_drive = 1'b0;

    drive("hold", 1'b0, 1'b0, 1'b0, 8'h00, {1'b0, 8'hFD});
    drive("wr_over_en", 1'b1, 1'b1, 1'b0, 8'h80, {1'b0, 8'h80});

    // async reset mid-cycle right after a wrap pulse
    drive("load_00", 1'b1, 1'b0, 1'b0, 8'h00, {1'b0, 8'h00});
    drive("downwrap_ff", 1'b0, 1'b1, 1'b1, 8'h00, {1'b1, 8'hFF});
    @(negedge clk);
    en = 1'b1; dir = 1'b0; wr = 1'b0; tb_drive = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("async_rst_count", {24'd0, addrOut}, 32'h00);
    check_eq("async_rst_ov", {31'd0, ov}, 32'd0);
    wr = 1'b1; tb_data = 8'h33; tb_drive = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_ignores_wr", {24'd0, addrOut}, 32'h00);
    @(negedge clk);
    wr = 1'b0; en = 1'b0; tb_drive = 1'b0;
    rst = 1'b0;

    // randomized run against the model, biased towards wrap boundaries
    m_count = '0;
    m_ov    = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rw = ($urandom_range(0, 7) == 0);
      re = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 4))
        0:       rdata = 8'h00;
        1:       rdata = 8'hFF;
        2:       rdata = 8'h01;
        3:       rdata = 8'hFE;
        default: rdata = W'($urandom_range(0, 255));
      endcase
      drive("random", rw, re, rd, rdata, predict(rw, re, rd, rdata));
    end

    check_eq("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_counter

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the counter, data-bus and address width.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 Port oe, input, 1 bit: output enable; drives the count onto dataBus.
REQ-005 Port wr, input, 1 bit: write strobe; loads the count from dataBus.
REQ-006 Port dir, input, 1 bit: count direction; 0 counts up, 1 counts down.
REQ-007 Port en, input, 1 bit: count enable.
REQ-008 Port dataBus, inout, WIDTH bits: shared tri-state system data bus.
REQ-009 Port addrOut, output, WIDTH bits: the current count, always driven.
REQ-010 Port ov, output, 1 bit: registered wrap/overflow flag.

Function
REQ-011 Count register SHALL be WIDTH bits, and addrOut SHALL equal the count register at all times.
REQ-012 Priority per rising clk edge SHALL be: wr > en > hold.
REQ-013 wr=1: count SHALL load dataBus on that edge; ov SHALL be cleared to 0; dir and en are ignored.
REQ-014 wr=0, en=1, dir=0: count SHALL become count+1 modulo 2^WIDTH.
REQ-015 wr=0, en=1, dir=1: count SHALL become count-1 modulo 2^WIDTH.
REQ-016 wr=0, en=0: count SHALL hold its value, and ov SHALL be cleared to 0.
REQ-017 ov SHALL be set to 1 on an edge where an up-count wraps all-ones to zero ($FF->$00), or where a down-count wraps zero to all-ones ($00->$FF).
REQ-018 ov SHALL be set to 0 on every other edge, so it is a one-cycle pulse coincident with the wrapped count value.
REQ-019 Load latency SHALL be one edge: the new value is visible on addrOut immediately after the edge on which wr=1.
REQ-020 Count latency SHALL be one edge per step.
REQ-021 dataBus SHALL be driven with the count when oe=1 and SHALL be high-impedance when oe=0.
REQ-022 oe SHALL be combinational and have no effect on state.
REQ-023 oe=1 together with wr=1 is illegal (bus contention): the count SHALL load whatever value dataBus resolves to, and no protection logic is required.
REQ-024 ov SHALL NOT be affected by oe.

Reset
REQ-025 rst=1 SHALL immediately and asynchronously force the count to 0 and ov to 0, independent of clk.
REQ-026 While rst=1, wr and en SHALL be ignored, and dataBus SHALL still follow oe (driving 0 when oe=1).
REQ-027 After rst deasserts, operation SHALL resume at the first rising clk edge.

Structure
REQ-028 The default WIDTH (8) SHALL live as a constant in the shared CPU package; no other typedefs are required.
REQ-029 The design SHALL be a single module with no sub-module; the tri-state driver SHALL be a continuous assignment inside counter.

Verification
REQ-030 Load: rst pulse, then wr=1 with dataBus=$10 for one edge -> addrOut=$10, ov=0.
REQ-031 Up-count: from $10, en=1, dir=0 for 5 edges -> addrOut steps $11,$12,$13,$14,$15; ov stays 0.
REQ-032 Up-wrap: load $FE, then en=1, dir=0 -> edge 1 gives addrOut=$FF, ov=0; edge 2 gives $00, ov=1; edge 3 gives $01, ov=0.
REQ-033 Down-count and down-wrap: load $05, then en=1, dir=1 for 8 edges -> $04,$03,$02,$01,$00,$FF,$FE,$FD; ov=1 only with the $FF step.
REQ-034 Bus/priority: oe=1 -> dataBus equals addrOut ($FD); oe=0 -> dataBus is Z; wr=1 and en=1 together with dataBus=$80 -> addrOut=$80, not incremented.
REQ-035 Async reset: assert rst mid-count between clk edges -> addrOut=$00 and ov=0 before the next edge.
